// File: rtl/fas_pkg.sv
// Shared constants and FSM state type for the frequency-analysis block.
package fas_pkg;

  localparam int FFT_POINTS = 16;
  localparam int HALF_W     = 16;
  localparam int MAG_W      = 32;
  localparam int IDX_W      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/fas_mag_sq.sv
// Combinational magnitude-squared of one complex bin: re^2 + im^2, unsigned.
module fas_mag_sq
  import fas_pkg::*;
#(
  parameter int HALF_W = 16
) (
  input  logic [2*HALF_W-1:0] bin,
  output logic [MAG_W-1:0]    mag
);

  logic signed [HALF_W-1:0] re;
  logic signed [HALF_W-1:0] im;
  logic signed [MAG_W-1:0]  re_sq;
  logic signed [MAG_W-1:0]  im_sq;

  assign re = bin[2*HALF_W-1:HALF_W];
  assign im = bin[HALF_W-1:0];

  // Each square is at most 2^30, so the unsigned sum tops out at 2^31 with no wrap.
  assign re_sq = MAG_W'(re) * MAG_W'(re);
  assign im_sq = MAG_W'(im) * MAG_W'(im);
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fas_freq_analysis.sv
// Peak-bin finder: latches a 16-bin FFT frame, scans one bin per cycle and reports the strongest.
module fas_freq_analysis
  import fas_pkg::*;
#(
  parameter int FFT_POINTS = 16,
  parameter int HALF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fft_valid,
  input  logic [2*HALF_W-1:0]   fft_d0,
  input  logic [2*HALF_W-1:0]   fft_d1,
  input  logic [2*HALF_W-1:0]   fft_d2,
  input  logic [2*HALF_W-1:0]   fft_d3,
  input  logic [2*HALF_W-1:0]   fft_d4,
  input  logic [2*HALF_W-1:0]   fft_d5,
  input  logic [2*HALF_W-1:0]   fft_d6,
  input  logic [2*HALF_W-1:0]   fft_d7,
  input  logic [2*HALF_W-1:0]   fft_d8,
  input  logic [2*HALF_W-1:0]   fft_d9,
  input  logic [2*HALF_W-1:0]   fft_d10,
  input  logic [2*HALF_W-1:0]   fft_d11,
  input  logic [2*HALF_W-1:0]   fft_d12,
  input  logic [2*HALF_W-1:0]   fft_d13,
  input  logic [2*HALF_W-1:0]   fft_d14,
  input  logic [2*HALF_W-1:0]   fft_d15,
  output logic                  done,
  output logic [IDX_W-1:0]      freq,
  output logic [MAG_W-1:0]      peak_mag,
  output logic                  busy,
  output logic                  drop
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINTS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [2*HALF_W-1:0]  fft_in [FFT_POINTS];
  logic [2*HALF_W-1:0]  buffer [FFT_POINTS];
  logic [MAG_W-1:0]     run_max;
  logic [IDX_W-1:0]     run_idx;
  logic [MAG_W-1:0]     mag;
  logic [MAG_W-1:0]     win_mag;
  logic [IDX_W-1:0]     win_idx;
  logic                 accept;
  logic                 last_step;
  logic                 take;

  assign fft_in[0]  = fft_d0;
  assign fft_in[1]  = fft_d1;
  assign fft_in[2]  = fft_d2;
  assign fft_in[3]  = fft_d3;
  assign fft_in[4]  = fft_d4;
  assign fft_in[5]  = fft_d5;
  assign fft_in[6]  = fft_d6;
  assign fft_in[7]  = fft_d7;
  assign fft_in[8]  = fft_d8;
  assign fft_in[9]  = fft_d9;
  assign fft_in[10] = fft_d10;
  assign fft_in[11] = fft_d11;
  assign fft_in[12] = fft_d12;
  assign fft_in[13] = fft_d13;
  assign fft_in[14] = fft_d14;
  assign fft_in[15] = fft_d15;

  // A new frame can land on the same edge that evaluates the last bin of the previous one.
  assign last_step = (state == SCAN) && (idx == LAST_IDX);
  assign accept    = fft_valid && ((state == IDLE) || last_step);
  assign busy      = (state == SCAN);

  fas_mag_sq #(.HALF_W(HALF_W)) u_mag_sq (
    .bin (buffer[idx]),
    .mag (mag)
  );

  // Strict compare keeps the earliest bin on ties; bin 0 seeds the running max.
  assign take    = (idx == '0) || (mag > run_max);
  assign win_mag = take ? mag : run_max;
  assign win_idx = take ? idx : run_idx;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (last_step) state_nxt = accept ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Frame storage needs no reset; the last-bin scan reads the old contents on the latching edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < FFT_POINTS; k++) buffer[k] <= fft_in[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      run_max  <= '0;
      run_idx  <= '0;
      freq     <= '0;
      peak_mag <= '0;
      done     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      done <= last_step;
      drop <= fft_valid && (state == SCAN) && (idx != LAST_IDX);
      if (accept || last_step) idx <= '0;
      else if (state == SCAN)  idx <= idx + 1'b1;
      if (state == SCAN) begin
        run_max <= win_mag;
        run_idx <= win_idx;
      end
      if (last_step) begin
        freq     <= win_idx;
        peak_mag <= win_mag;
      end
    end
  end

endmodule

// File: tb/tb_fas_freq_analysis.sv
// Randomized and directed bench for fas_freq_analysis against an arithmetic peak-search model.
module tb_fas_freq_analysis;

  typedef logic [31:0] frame_t [16];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic [31:0] bins_in [16];
  logic        done;
  logic [3:0]  freq;
  logic [31:0] peak_mag;
  logic        busy;
  logic        drop;

  int n_checks = 0;
  int n_pass   = 0;
  int edges    = 0;
  int free_edge = 0;

  // Scoreboard: expected completion edges/results, drop edges, accepted-frame edges.
  int          done_edge_q [$];
  logic [3:0]  exp_q_freq  [$];
  logic [31:0] exp_q       [$];
  int          drop_edge_q [$];
  int          acc_q       [$];
  logic [3:0]  held_freq = '0;
  logic [31:0] held_mag  = '0;

  fas_freq_analysis dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(bins_in[0]),   .fft_d1(bins_in[1]),   .fft_d2(bins_in[2]),   .fft_d3(bins_in[3]),
    .fft_d4(bins_in[4]),   .fft_d5(bins_in[5]),   .fft_d6(bins_in[6]),   .fft_d7(bins_in[7]),
    .fft_d8(bins_in[8]),   .fft_d9(bins_in[9]),   .fft_d10(bins_in[10]), .fft_d11(bins_in[11]),
    .fft_d12(bins_in[12]), .fft_d13(bins_in[13]), .fft_d14(bins_in[14]), .fft_d15(bins_in[15]),
    .done(done), .freq(freq), .peak_mag(peak_mag), .busy(busy), .drop(drop)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at edge %0d", tag, got, exp, edges);
  endtask

  task automatic clear_model();
    done_edge_q.delete(); exp_q_freq.delete(); exp_q.delete();
    drop_edge_q.delete(); acc_q.delete();
    free_edge = 0;
    held_freq = '0;
    held_mag  = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    clear_model();
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  task automatic model_frame(input frame_t f, input int e);
    longint best;
    longint m;
    int     best_k;
    int     re;
    int     im;
    if (e >= free_edge) begin
      best = -1;
      best_k = 0;
      for (int k = 0; k < 16; k++) begin
        re = int'($signed(f[k][31:16]));
        im = int'($signed(f[k][15:0]));
        m = longint'(re) * re + longint'(im) * im;
        if (m > best) begin
          best = m;
          best_k = k;
        end
      end
      acc_q.push_back(e);
      free_edge = e + 16;
      done_edge_q.push_back(e + 16);
      exp_q_freq.push_back(4'(best_k));
      exp_q.push_back(32'(best));
    end else begin
      drop_edge_q.push_back(e);
    end
  endtask

  function automatic logic exp_busy(input int e);
    logic b = 1'b0;
    foreach (acc_q[i]) if (acc_q[i] <= e && e < acc_q[i] + 16) b = 1'b1;
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble_bins();
    for (int k = 0; k < 16; k++) bins_in[k] = $urandom;
  endtask

  task automatic send_frame(input frame_t f);
    for (int k = 0; k < 16; k++) bins_in[k] = f[k];
    fft_valid = 1'b1;
    model_frame(f, edges + 1);
    @(negedge clk);
    fft_valid = 1'b0;
    scramble_bins();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic frame_t zero_frame();
    frame_t f;
    for (int k = 0; k < 16; k++) f[k] = '0;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    logic [31:0] pool [6];
    pool[0] = 32'h0000_0000; pool[1] = 32'h0100_0000; pool[2] = 32'h0000_FF00;
    pool[3] = 32'h8000_8000; pool[4] = 32'hFF00_0100; pool[5] = 32'h0200_0000;
    for (int k = 0; k < 16; k++)
      f[k] = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
    return f;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done_edge_q.size() > 0 && done_edge_q[0] < edges) begin
          check("done_missing", 32'(edges), 32'(done_edge_q[0]));
          void'(done_edge_q.pop_front()); void'(exp_q_freq.pop_front()); void'(exp_q.pop_front());
        end
        if (done) begin
          if (done_edge_q.size() == 0) begin
            check("done_unexpected", 32'(done), 32'd0);
          end else begin
            check("done_edge", 32'(edges), 32'(done_edge_q.pop_front()));
            held_freq = exp_q_freq.pop_front();
            held_mag  = exp_q.pop_front();
          end
        end
        if (drop_edge_q.size() > 0 && drop_edge_q[0] < edges) begin
          check("drop_missing", 32'(edges), 32'(drop_edge_q[0]));
          void'(drop_edge_q.pop_front());
        end
        if (drop) begin
          if (drop_edge_q.size() == 0) check("drop_unexpected", 32'(drop), 32'd0);
          else check("drop_edge", 32'(edges), 32'(drop_edge_q.pop_front()));
        end
      end
      check("freq", 32'(freq), 32'(held_freq));
      check("peak_mag", peak_mag, held_mag);
      check("busy", 32'(busy), 32'(exp_busy(edges) && !rst));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    frame_t f;
    scramble_bins();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_done", 32'(done), 32'd0);
    check("reset_drop", 32'(drop), 32'd0);

    // single peak at bin 5
    f = zero_frame(); f[5] = 32'h0100_0000;
    send_frame(f);
    idle(20);

    // tie: bins 3 and 9 equal magnitude
    f = zero_frame(); f[3] = 32'h0000_FE00; f[9] = 32'h0200_0000;
    send_frame(f);
    idle(18);

    // extreme values, largest magnitude with no wrap
    for (int k = 0; k < 16; k++) f[k] = 32'h7FFF_7FFF;
    f[12] = 32'h8000_8000;
    send_frame(f);
    idle(18);

    // back-to-back, then a frame landing mid-scan
    f = zero_frame(); f[2] = 32'h0040_0000;
    send_frame(f);
    idle(15);
    f = zero_frame(); f[14] = 32'h0000_0300;
    send_frame(f);
    idle(7);
    f = zero_frame(); f[7] = 32'h7000_0000;
    send_frame(f);
    idle(20);

    // reset mid-scan at idx 7, then a frame peaking at bin 0
    f = zero_frame(); f[4] = 32'h0100_0100;
    send_frame(f);
    repeat (6) @(posedge clk);
    do_reset();
    check("post_reset_busy", 32'(busy), 32'd0);
    f = zero_frame(); f[0] = 32'hFD00_0080; f[1] = 32'h0100_0000;
    send_frame(f);
    idle(20);

    // random frames with random gaps (some land mid-scan and must be dropped)
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 20));
      send_frame(rand_frame());
    end
    idle(40);
    check("pending_done", 32'(done_edge_q.size()), 32'd0);
    check("pending_drop", 32'(drop_edge_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
